// File: rtl/burst_pkg.sv
// Shared types and constants for the line-to-beat burst responder.
package burst_pkg;

  localparam int S_OFFSET   = 5;
  localparam int S_LINE     = 256;
  localparam int S_BEAT     = 64;
  localparam int N_BEATS    = S_LINE / S_BEAT;
  localparam int BEAT_IDX_W = 2;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST,
    RESP
  } burst_state_t;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(N_BEATS - 1);

  // Byte offset within a line; cleared to form the burst address.
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << S_OFFSET) - 1);

  // Line-align an address by clearing the offset bits.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/line_burst_responder.sv
// Responder for 256-bit line requests, performed as 4-beat 64-bit bursts.
// Read beats are packed into a line (beat 0 in the LSBs); write lines are
// sent out beat by beat. One request at a time; completion is a one-cycle
// pmem_resp pulse. All outputs come from registers or decoded state.
module line_burst_responder
  import burst_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  // line-side request port
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic [ADDR_W-1:0]   pmem_address,
  input  logic [S_LINE-1:0]   pmem_wdata,
  output logic [S_LINE-1:0]   pmem_rdata,
  output logic                pmem_resp,
  // narrow burst memory port
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [S_BEAT-1:0]   mem_wdata,
  input  logic [S_BEAT-1:0]   mem_rdata,
  input  logic                mem_resp
);

  burst_state_t        state_reg, state_next;
  beat_idx_t           beat_reg,  beat_next;
  logic [ADDR_W-1:0]   addr_reg,  addr_next;
  logic [S_LINE-1:0]   wline_reg, wline_next;
  logic [S_LINE-1:0]   rline_reg, rline_next;

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      addr_reg  <= '0;
      wline_reg <= '0;
      rline_reg <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      addr_reg  <= addr_next;
      wline_reg <= wline_next;
      rline_reg <= rline_next;
    end
  end

  // Next-state: accept a request in IDLE (write has priority), advance one
  // beat per mem_resp, leave the burst after the last beat.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    addr_next  = addr_reg;
    wline_next = wline_reg;
    rline_next = rline_reg;

    unique case (state_reg)
      IDLE: begin
        if (pmem_write) begin
          state_next = WBURST;
          addr_next  = line_align(pmem_address);
          wline_next = pmem_wdata;
          beat_next  = '0;
        end else if (pmem_read) begin
          state_next = RBURST;
          addr_next  = line_align(pmem_address);
          beat_next  = '0;
        end
      end

      RBURST: begin
        // mem_resp low is a wait state: nothing moves.
        if (mem_resp) begin
          rline_next[beat_reg*S_BEAT +: S_BEAT] = mem_rdata;
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = RESP;
          end
        end
      end

      WBURST: begin
        if (mem_resp) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = RESP;
          end
        end
      end

      RESP: begin
        // Requests still held here belong to the finished transfer.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: strobes and completion from state, data from registers.
  assign mem_read    = (state_reg == RBURST);
  assign mem_write   = (state_reg == WBURST);
  assign pmem_resp   = (state_reg == RESP);
  assign mem_address = addr_reg;
  assign mem_wdata   = wline_reg[beat_reg*S_BEAT +: S_BEAT];
  assign pmem_rdata  = rline_reg;

endmodule

// File: tb/tb_line_burst_responder.sv
// Bench for line_burst_responder: directed table, hand-written reset and
// back-to-back sequences, and random traffic against a line-level memory.
module tb_line_burst_responder;

  logic          clk = 1'b0;
  logic          rst;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [255:0]  pmem_wdata;
  logic [255:0]  pmem_rdata;
  logic          pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_burst_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  localparam logic [255:0] L_A   = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] L_W   = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [255:0] L_B   = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
  localparam logic [255:0] L_C   = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                                    64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF};
  localparam logic [255:0] L_D   = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                    64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
  localparam logic [255:0] L_F   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                    64'hCAFE_F00D_DEAD_BEEF, 64'h1357_9BDF_2468_ACE0};
  localparam logic [255:0] L_E   = {64'h5A5A_0000_1111_0003, 64'h5A5A_0000_1111_0002,
                                    64'h5A5A_0000_1111_0001, 64'h5A5A_0000_1111_0000};
  localparam logic [255:0] L_BAD = {4{64'hBAD0_BAD0_BAD0_BAD0}};

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wline;
    logic [255:0] rline;      // what the memory returns, beat 0 in the LSBs
    logic [15:0]  waits;      // nibble k = wait cycles before beat k
    int           exp_cycle;  // cycle of pmem_resp, request seen at cycle 0
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Line-level reference memory (ref_mem, from pmem_wdata) and the beat-level
  // memory the bus model serves (bus_mem, from captured mem_wdata beats).
  logic [255:0] ref_mem [8];
  logic [255:0] bus_mem [8];
  logic [255:0] model_rdata;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one request and act as the memory; returns the completion cycle,
  // the line seen on mem_wdata, and pmem_rdata at and after completion.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input logic [255:0] wline,
                         input logic [255:0] rline, input logic [3:0][3:0] waits,
                         output int resp_cycle, output logic [255:0] got_wline,
                         output logic [255:0] rdata_resp, output logic [255:0] rdata_after);
    bit is_wr;
    bit is_rd;
    int k;
    int wcnt;
    is_wr       = wr;
    is_rd       = rd && !wr;
    got_wline   = '0;
    rdata_resp  = '0;
    rdata_after = '0;
    resp_cycle  = -1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wline;
    mem_resp     = 1'b0;
    @(posedge clk); #1;
    k    = 0;
    wcnt = 0;
    for (int c = 1; c < 40; c++) begin
      if (k == 4) begin
        resp_cycle = c;
        chk("resp_pulse", 256'(pmem_resp), 256'(1'b1));
        chk("resp_strobes", 256'({mem_read, mem_write}), 256'(2'b00));
        rdata_resp = pmem_rdata;
        break;
      end
      chk("resp_early", 256'(pmem_resp), 256'(1'b0));
      chk("mem_read", 256'(mem_read), 256'(is_rd));
      chk("mem_write", 256'(mem_write), 256'(is_wr));
      chk("mem_address", 256'(mem_address), 256'(exp_addr));
      if (is_wr) chk("mem_wdata", 256'(mem_wdata), 256'(wline[k*64 +: 64]));
      if (wcnt < int'(waits[k])) begin
        mem_resp = 1'b0;
        wcnt++;
      end else begin
        mem_resp  = 1'b1;
        mem_rdata = rline[k*64 +: 64];
        if (is_wr) got_wline[k*64 +: 64] = mem_wdata;
      end
      @(posedge clk); #1;
      if (mem_resp) begin
        k++;
        wcnt = 0;
      end
      mem_resp  = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
    if (resp_cycle < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no pmem_resp, expected one within 40 cycles");
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      return;
    end
    // First IDLE cycle: requests were still high during RESP and must have
    // been ignored. A stray mem_resp here must be ignored too.
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    chk("idle_resp", 256'(pmem_resp), 256'(1'b0));
    chk("idle_strobes", 256'({mem_read, mem_write}), 256'(2'b00));
    mem_resp  = 1'b1;
    mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    mem_resp = 1'b0;
    chk("idle_hold", 256'({mem_read, mem_write, pmem_resp}), 256'(3'b000));
    rdata_after = pmem_rdata;
    $display("txn rd=%0b wr=%0b addr=%08h resp_cycle=%0d rdata=%h", rd, wr, addr, resp_cycle, rdata_after);
  endtask

  // Request against the line memory; expectations come from ref_mem.
  task automatic mem_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [15:0] waits);
    int idx;
    int exp_cycle;
    int rc;
    logic [255:0] gw;
    logic [255:0] rr;
    logic [255:0] ra;
    idx = int'(addr[7:5]);
    exp_cycle = 5;
    for (int b = 0; b < 4; b++) exp_cycle += int'(waits[b*4 +: 4]);
    run_txn(rd, wr, addr, {addr[31:5], 5'b0}, wdata, bus_mem[idx], waits, rc, gw, rr, ra);
    if (wr) begin
      chk("mem_line_written", gw, wdata);
      bus_mem[idx] = gw;
      ref_mem[idx] = wdata;
    end else begin
      model_rdata = ref_mem[idx];
    end
    chk("mem_resp_cycle", 256'(rc), 256'(exp_cycle));
    chk("mem_rdata_resp", rr, model_rdata);
    chk("mem_rdata_after", ra, model_rdata);
  endtask

  initial begin
    int rc;
    logic [255:0] gw;
    logic [255:0] rr;
    logic [255:0] ra;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0,    L_A,   16'h0000, 5,  L_A};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_00E0, 32'h8000_00E0, L_W,   L_BAD, 16'h0000, 5,  L_A};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2A5F, 32'h0000_2A40, '0,    L_B,   16'h0200, 7,  L_B};
    vecs[3] = '{1'b1, 1'b1, 32'h1234_567C, 32'h1234_5660, L_C,   L_BAD, 16'h0000, 5,  L_B};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, L_D,   L_BAD, 16'h1001, 7,  L_B};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_001F, 32'h0000_0000, '0,    L_W,   16'h2222, 13, L_W};

    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pmem_resp", 256'(pmem_resp), 256'(1'b0));
    chk("rst_strobes", 256'({mem_read, mem_write}), 256'(2'b00));
    chk("rst_mem_address", 256'(mem_address), 256'(32'h0));
    chk("rst_mem_wdata", 256'(mem_wdata), 256'(64'h0));
    chk("rst_pmem_rdata", pmem_rdata, 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 256'({mem_read, mem_write, pmem_resp}), 256'(3'b000));

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].exp_addr, vecs[i].wline,
              vecs[i].rline, vecs[i].waits, rc, gw, rr, ra);
      chk("tbl_resp_cycle", 256'(rc), 256'(vecs[i].exp_cycle));
      chk("tbl_rdata_resp", rr, vecs[i].exp_rdata);
      chk("tbl_rdata_after", ra, vecs[i].exp_rdata);
      if (vecs[i].wr) chk("tbl_wline", gw, vecs[i].wline);
    end

    // Reset after beat 1 of a read: outputs clear, no completion follows.
    pmem_read    = 1'b1;
    pmem_write   = 1'b0;
    pmem_address = 32'h0000_0300;
    @(posedge clk); #1;
    chk("abort_mem_read", 256'(mem_read), 256'(1'b1));
    mem_resp  = 1'b1;
    mem_rdata = 64'hAAAA_0000_0000_0001;
    @(posedge clk); #1;
    mem_rdata = 64'hAAAA_0000_0000_0002;
    @(posedge clk); #1;
    mem_resp  = 1'b0;
    rst       = 1'b1;
    pmem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_strobes", 256'({mem_read, mem_write}), 256'(2'b00));
    chk("abort_pmem_resp", 256'(pmem_resp), 256'(1'b0));
    chk("abort_mem_address", 256'(mem_address), 256'(32'h0));
    chk("abort_mem_wdata", 256'(mem_wdata), 256'(64'h0));
    chk("abort_pmem_rdata", pmem_rdata, 256'(0));
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", 256'({mem_read, pmem_resp}), 256'(2'b00));
      @(posedge clk); #1;
    end
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0300, '0, L_F, 16'h0010, rc, gw, rr, ra);
    chk("clean_resp_cycle", 256'(rc), 256'(6));
    chk("clean_rdata", rr, L_F);

    // Line memory, seeded identically on both sides.
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = rand256();
      bus_mem[i] = ref_mem[i];
    end
    model_rdata = L_F;

    // Back-to-back write then read of the same line.
    mem_txn(1'b0, 1'b1, 32'h0040_0067, L_E, 16'h0000);
    mem_txn(1'b1, 1'b0, 32'h0040_0060, '0,  16'h0000);
    chk("b2b_read_back", pmem_rdata, L_E);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [31:0] addr;
      logic [15:0] w;
      kind = int'($urandom_range(0, 9));
      addr = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      w = '0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) w[b*4 +: 4] = 4'($urandom_range(1, 2));
      end
      if (kind < 5)      mem_txn(1'b1, 1'b0, addr, rand256(), w);
      else if (kind < 9) mem_txn(1'b0, 1'b1, addr, rand256(), w);
      else               mem_txn(1'b1, 1'b1, addr, rand256(), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected one before time limit");
    $fatal(1);
  end

endmodule
